a2d_spi_intf: RTL

//  SPI master to the 8-channel 12-bit line-sensor A2D (ADC128S-style). Sits directly upstream
//  of the motion controller: consumes its strt_cnv/chnnl request, runs two back-to-back 16-bit
//  SPI transactions (channel select, then readback), returns the 12-bit result plus cnv_cmplt.

---
 rtl/a2d_spi_intf_if.sv | 53 +++++
 rtl/a2d_spi_intf.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/a2d_spi_intf_if.sv
// ============================================================================
//  Module      : a2d_spi_intf_if
//  Description : Bundle of the signals of the line-sensor A2D SPI master.
//                It carries the conversion handshake with the motion
//                controller and the 4-wire SPI bus to the ADC128S-style A2D.
//                  strt_cnv   1   request to start a conversion
//                  chnnl      3   channel to convert
//                  cnv_cmplt  1   level, result valid
//                  res        12  last conversion result
//                  SS_n       1   SPI slave select, active-low
//                  SCLK       1   SPI clock, idles high
//                  MOSI       1   SPI data to the A2D
//                  MISO       1   SPI data from the A2D
//                The master modport is the SPI master itself. The slave
//                modport is the far side: the requester plus the A2D.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface a2d_spi_intf_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  strt_cnv,
        input  chnnl,
        input  MISO,
        output cnv_cmplt,
        output res,
        output SS_n,
        output SCLK,
        output MOSI
    );

    modport slave (
        output strt_cnv,
        output chnnl,
        output MISO,
        input  cnv_cmplt,
        input  res,
        input  SS_n,
        input  SCLK,
        input  MOSI
    );
endinterface

`default_nettype wire

// File: rtl/a2d_spi_intf.sv
// ============================================================================
//  Module      : a2d_spi_intf
//  Description : SPI master for the 8-channel 12-bit line-sensor A2D.
//                A conversion is two 16-bit SPI transactions separated by a
//                short SS_n-high pause. The first one sends the channel
//                select, and the second one reads the converted result back.
//                The 12-bit result is presented on res and qualified by
//                cnv_cmplt.
//  Parameters  : DIV_W       SCLK divider width, SCLK period = 2^DIV_W clk
//                PAUSE_CLKS  clk cycles SS_n is held high between transactions
//  Ports       : clk    in  system clock
//                rst_n  in  asynchronous active-low reset
//                bus    --  a2d_spi_intf_if.master:
//                           strt_cnv/chnnl in, cnv_cmplt/res out,
//                           SS_n/SCLK/MOSI out, MISO in
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module a2d_spi_intf #(
    parameter int DIV_W      = 5,
    parameter int PAUSE_CLKS = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    a2d_spi_intf_if.master bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TX1   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_TX2   = 2'd3;

    // The divider is loaded 9 counts short of wrapping. SCLK therefore stays
    // high for 9 clk after SS_n falls, then spends half a period low before
    // the first rising edge. This gives the A2D setup time on the first bit.
    localparam logic [DIV_W-1:0] C_DIV_LOAD = DIV_W'((1 << DIV_W) - 9);
    // Divider value just before the MSB sets (SCLK rises).
    localparam logic [DIV_W-1:0] C_DIV_RISE = {1'b0, {(DIV_W-1){1'b1}}};
    // Divider value just before wrap (SCLK falls).
    localparam logic [DIV_W-1:0] C_DIV_FALL = {DIV_W{1'b1}};
    localparam logic [4:0]       C_BITS     = 5'd16;

    localparam int               PCW          = (PAUSE_CLKS > 1) ? $clog2(PAUSE_CLKS) : 1;
    localparam logic [PCW-1:0]   C_PAUSE_LAST = PCW'(PAUSE_CLKS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state_q,     state_d;
    logic [DIV_W-1:0] sclk_div_q,  sclk_div_d;
    logic [4:0]       bit_cnt_q,   bit_cnt_d;
    logic [15:0]      tx_shft_q,   tx_shft_d;
    // Only the low 12 bits of the 16 received bits are ever used. Shifting
    // 16 bits through a 12-bit register drops the leading nibble naturally.
    logic [11:0]      rx_shft_q,   rx_shft_d;
    logic [PCW-1:0]   pause_cnt_q, pause_cnt_d;
    logic             ss_n_q,      ss_n_d;
    logic             sclk_q,      sclk_d;
    logic             cnv_cmplt_q, cnv_cmplt_d;
    logic [11:0]      res_q,       res_d;

    logic             w_div_rise;
    logic             w_div_fall;
    logic             w_tx_done;

    assign w_div_rise = (sclk_div_q == C_DIV_RISE);
    assign w_div_fall = (sclk_div_q == C_DIV_FALL);
    // The 16th bit has been sampled and the divider has reached its last
    // count. SS_n is released here instead of producing a 17th SCLK fall.
    assign w_tx_done  = w_div_fall && (bit_cnt_q == C_BITS);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sclk_div_d  = sclk_div_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shft_d   = tx_shft_q;
        rx_shft_d   = rx_shft_q;
        pause_cnt_d = pause_cnt_q;
        ss_n_d      = ss_n_q;
        cnv_cmplt_d = cnv_cmplt_q;
        res_d       = res_q;

        case (state_q)
            S_IDLE: begin
                // Requests are only honoured here, so a strt_cnv during a
                // conversion (including its final edge) is dropped.
                if (bus.strt_cnv) begin
                    ss_n_d      = 1'b0;
                    sclk_div_d  = C_DIV_LOAD;
                    bit_cnt_d   = 5'd0;
                    cnv_cmplt_d = 1'b0;
                    tx_shft_d   = {2'b00, bus.chnnl, 11'h000};
                    state_d     = S_TX1;
                end
            end

            S_TX1, S_TX2: begin
                if (w_tx_done) begin
                    ss_n_d = 1'b1;
                    if (state_q == S_TX1) begin
                        pause_cnt_d = '0;
                        state_d     = S_PAUSE;
                    end else begin
                        res_d       = rx_shft_q;
                        cnv_cmplt_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else begin
                    sclk_div_d = sclk_div_q + DIV_W'(1);
                    if (w_div_rise) begin
                        rx_shft_d = {rx_shft_q[10:0], bus.MISO};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                    // The divider also wraps once before the first rise. That
                    // fall must not shift, or the MSB on MOSI would be lost.
                    if (w_div_fall && (bit_cnt_q != 5'd0)) begin
                        tx_shft_d = {tx_shft_q[14:0], 1'b0};
                    end
                end
            end

            S_PAUSE: begin
                if (pause_cnt_q == C_PAUSE_LAST) begin
                    ss_n_d     = 1'b0;
                    sclk_div_d = C_DIV_LOAD;
                    bit_cnt_d  = 5'd0;
                    tx_shft_d  = 16'h0000;
                    state_d    = S_TX2;
                end else begin
                    pause_cnt_d = pause_cnt_q + PCW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // SCLK is registered from the next-state values so that the pin
        // comes straight from a flop. It is forced high whenever SS_n is high.
        sclk_d = ss_n_d | sclk_div_d[DIV_W-1];
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sclk_div_q  <= '0;
            bit_cnt_q   <= 5'd0;
            tx_shft_q   <= 16'h0000;
            rx_shft_q   <= 12'h000;
            pause_cnt_q <= '0;
            ss_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            cnv_cmplt_q <= 1'b0;
            res_q       <= 12'h000;
        end else begin
            state_q     <= state_d;
            sclk_div_q  <= sclk_div_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shft_q   <= tx_shft_d;
            rx_shft_q   <= rx_shft_d;
            pause_cnt_q <= pause_cnt_d;
            ss_n_q      <= ss_n_d;
            sclk_q      <= sclk_d;
            cnv_cmplt_q <= cnv_cmplt_d;
            res_q       <= res_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.SS_n      = ss_n_q;
    assign bus.SCLK      = sclk_q;
    assign bus.MOSI      = tx_shft_q[15];
    assign bus.cnv_cmplt = cnv_cmplt_q;
    assign bus.res       = res_q;

endmodule

`default_nettype wire
